// File: rtl/hazard_stall_unit_if.sv
// Bundle between the pipeline control and the hazard/stall unit: register
// addresses and pipeline status in, stall/bubble/flush/freeze controls out.
interface hazard_stall_unit_if #(
  parameter int AddrBits = 3,
  parameter int CntBits  = 16
);
  logic [AddrBits-1:0] IF_ID_Rs;
  logic [AddrBits-1:0] IF_ID_Rt;
  logic                IF_ID_UsesRt;
  logic [AddrBits-1:0] ID_EX_Rt;
  logic                ID_EX_MemRead;
  logic                Branch_Taken;
  logic                Mem_Busy;
  logic                Stall;
  logic                ID_EX_Bubble;
  logic                IF_ID_Flush;
  logic                Freeze;
  logic                Mem_Error;
  logic [CntBits-1:0]  Stall_Count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_Rt, ID_EX_MemRead,
           Branch_Taken, Mem_Busy,
    input  Stall, ID_EX_Bubble, IF_ID_Flush, Freeze, Mem_Error, Stall_Count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_Rt, ID_EX_MemRead,
           Branch_Taken, Mem_Busy,
    output Stall, ID_EX_Bubble, IF_ID_Flush, Freeze, Mem_Error, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector with multi-cycle stalls, memory-busy freeze with
// sticky timeout error, branch-flush priority and a saturating stall counter.
module hazard_stall_unit #(
  parameter int AddrBits        = 3,
  parameter int LoadStallCycles = 1,
  parameter int ZeroRegFixed    = 1,
  parameter int MemTimeout      = 64,
  parameter int CntBits         = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  hazard_stall_unit_if.slave bus
);

  localparam int TmrBits = $clog2(MemTimeout + 1);
  localparam logic [3:0]         LoadReload = 4'(LoadStallCycles - 1);
  localparam logic [TmrBits-1:0] TmrLimit   = TmrBits'(MemTimeout);

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [TmrBits-1:0] busy_tmr_q, busy_tmr_d;
  logic               mem_error_q, mem_error_d;
  logic [CntBits-1:0] stall_count_q, stall_count_d;

  logic hazard;
  logic rs_match;
  logic rt_match;
  logic zero_dst;
  logic stall;
  logic bubble;
  logic flush;
  logic freeze;

  function automatic logic [CntBits-1:0] sat_inc_cnt(input logic [CntBits-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TmrBits-1:0] sat_inc_tmr(input logic [TmrBits-1:0] v);
    return (v == TmrLimit) ? v : v + 1'b1;
  endfunction

  always_comb begin
    rs_match = (bus.IF_ID_Rs == bus.ID_EX_Rt);
    rt_match = bus.IF_ID_UsesRt && (bus.IF_ID_Rt == bus.ID_EX_Rt);
    zero_dst = (ZeroRegFixed != 0) && (bus.ID_EX_Rt == '0);
    hazard   = bus.ID_EX_MemRead && (rs_match || rt_match) && !zero_dst;
  end

  // Freeze dominates everything; a taken branch dominates any load stall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_tmr_d    = '0;
    mem_error_d   = mem_error_q;
    stall_count_d = stall_count_q;
    stall         = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    freeze        = 1'b0;

    if (bus.Mem_Busy) begin
      freeze     = 1'b1;
      busy_tmr_d = sat_inc_tmr(busy_tmr_q);
      if (busy_tmr_d == TmrLimit) begin
        mem_error_d = 1'b1;
      end
    end else if (bus.Branch_Taken) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LoadStallCycles > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LoadReload;
            end
          end
        end
        LOAD_STALL: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    if (stall) begin
      stall_count_d = sat_inc_cnt(stall_count_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      busy_tmr_q    <= '0;
      mem_error_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_tmr_q    <= busy_tmr_d;
      mem_error_q   <= mem_error_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Single-bit controls are held low for as long as reset is asserted.
  assign bus.Stall        = stall  & Reset_n;
  assign bus.ID_EX_Bubble = bubble & Reset_n;
  assign bus.IF_ID_Flush  = flush  & Reset_n;
  assign bus.Freeze       = freeze & Reset_n;
  assign bus.Mem_Error    = mem_error_q & Reset_n;
  assign bus.Stall_Count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: unit A (3-cycle load stall, zero reg fixed, 16-bit counter)
// and unit B (1-cycle stall, zero reg hazardous, 2-bit counter).
module tb_hazard_stall_unit;

  logic Clk;
  logic Reset_n_a;
  logic Reset_n_b;
  int   checks;
  int   errors;

  hazard_stall_unit_if #(.AddrBits(3), .CntBits(16)) ifa ();
  hazard_stall_unit_if #(.AddrBits(3), .CntBits(2))  ifb ();

  hazard_stall_unit #(
    .AddrBits(3), .LoadStallCycles(3), .ZeroRegFixed(1), .MemTimeout(64), .CntBits(16)
  ) dut_a (
    .Clk     (Clk),
    .Reset_n (Reset_n_a),
    .bus     (ifa)
  );

  hazard_stall_unit #(
    .AddrBits(3), .LoadStallCycles(1), .ZeroRegFixed(0), .MemTimeout(64), .CntBits(2)
  ) dut_b (
    .Clk     (Clk),
    .Reset_n (Reset_n_b),
    .bus     (ifb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_a();
    ifa.IF_ID_Rs      = '0;
    ifa.IF_ID_Rt      = '0;
    ifa.IF_ID_UsesRt  = 1'b0;
    ifa.ID_EX_Rt      = '0;
    ifa.ID_EX_MemRead = 1'b0;
    ifa.Branch_Taken  = 1'b0;
    ifa.Mem_Busy      = 1'b0;
  endtask

  task automatic clr_b();
    ifb.IF_ID_Rs      = '0;
    ifb.IF_ID_Rt      = '0;
    ifb.IF_ID_UsesRt  = 1'b0;
    ifb.ID_EX_Rt      = '0;
    ifb.ID_EX_MemRead = 1'b0;
    ifb.Branch_Taken  = 1'b0;
    ifb.Mem_Busy      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_a();
    clr_b();
    Reset_n_a = 1'b0;
    Reset_n_b = 1'b0;

    // Reset: a live hazard and busy are masked while reset is low
    ifa.IF_ID_Rs = 3'd3; ifa.ID_EX_Rt = 3'd3; ifa.ID_EX_MemRead = 1'b1;
    ifb.Mem_Busy = 1'b1;
    settle();
    chk("rst_stall_forced", 32'(ifa.Stall), 32'd0);
    chk("rst_bubble_forced", 32'(ifa.ID_EX_Bubble), 32'd0);
    chk("rst_freeze_forced", 32'(ifb.Freeze), 32'd0);
    tick();
    tick();
    clr_a();
    clr_b();
    Reset_n_a = 1'b1;
    Reset_n_b = 1'b1;
    settle();
    chk("rst_count_a", 32'(ifa.Stall_Count), 32'd0);
    chk("rst_count_b", 32'(ifb.Stall_Count), 32'd0);
    chk("rst_mem_error", 32'(ifa.Mem_Error), 32'd0);
    chk("rst_flush", 32'(ifa.IF_ID_Flush), 32'd0);

    // Unit B: address comparison and UsesRt qualification
    tick();
    ifb.IF_ID_Rs = 3'd2; ifb.IF_ID_Rt = 3'd3; ifb.ID_EX_Rt = 3'd4;
    ifb.ID_EX_MemRead = 1'b1; ifb.IF_ID_UsesRt = 1'b1;
    settle();
    chk("b_no_match", 32'(ifb.Stall), 32'd0);
    ifb.ID_EX_Rt = 3'd3; ifb.IF_ID_UsesRt = 1'b0;
    settle();
    chk("b_rt_unused", 32'(ifb.Stall), 32'd0);
    ifb.IF_ID_UsesRt = 1'b1;
    settle();
    chk("b_rt_hazard_stall", 32'(ifb.Stall), 32'd1);
    chk("b_rt_hazard_bubble", 32'(ifb.ID_EX_Bubble), 32'd1);
    tick();
    ifb.ID_EX_MemRead = 1'b0;
    settle();
    chk("b_single_cycle", 32'(ifb.Stall), 32'd0);
    chk("b_count_1", 32'(ifb.Stall_Count), 32'd1);

    // Unit B: register 0 is a real hazard, and the 2-bit counter saturates
    ifb.IF_ID_Rs = 3'd0; ifb.ID_EX_Rt = 3'd0; ifb.ID_EX_MemRead = 1'b1; ifb.IF_ID_UsesRt = 1'b0;
    settle();
    chk("b_zero_reg_hazard", 32'(ifb.Stall), 32'd1);
    tick();
    tick();
    settle();
    chk("b_count_3", 32'(ifb.Stall_Count), 32'd3);
    tick();
    tick();
    settle();
    chk("b_count_sat", 32'(ifb.Stall_Count), 32'd3);
    chk("b_still_stall", 32'(ifb.Stall), 32'd1);
    clr_b();

    // Unit A: register 0 never stalls
    ifa.IF_ID_Rs = 3'd0; ifa.IF_ID_Rt = 3'd0; ifa.IF_ID_UsesRt = 1'b1;
    ifa.ID_EX_Rt = 3'd0; ifa.ID_EX_MemRead = 1'b1;
    settle();
    chk("a_zero_reg_masked", 32'(ifa.Stall), 32'd0);
    clr_a();

    // Unit A: one hazard cycle gives exactly three stall cycles
    ifa.IF_ID_Rs = 3'd5; ifa.ID_EX_Rt = 3'd5; ifa.ID_EX_MemRead = 1'b1;
    settle();
    chk("a_ls_c1_stall", 32'(ifa.Stall), 32'd1);
    chk("a_ls_c1_bubble", 32'(ifa.ID_EX_Bubble), 32'd1);
    tick();
    clr_a();
    settle();
    chk("a_ls_c2", 32'(ifa.Stall), 32'd1);
    tick();
    settle();
    chk("a_ls_c3", 32'(ifa.Stall), 32'd1);
    tick();
    settle();
    chk("a_ls_done", 32'(ifa.Stall), 32'd0);
    chk("a_count_3", 32'(ifa.Stall_Count), 32'd3);

    // Unit A: branch beats a simultaneous hazard
    ifa.IF_ID_Rs = 3'd5; ifa.ID_EX_Rt = 3'd5; ifa.ID_EX_MemRead = 1'b1; ifa.Branch_Taken = 1'b1;
    settle();
    chk("a_br_flush", 32'(ifa.IF_ID_Flush), 32'd1);
    chk("a_br_no_stall", 32'(ifa.Stall), 32'd0);
    chk("a_br_bubble", 32'(ifa.ID_EX_Bubble), 32'd1);
    tick();
    clr_a();
    settle();
    chk("a_br_next_run", 32'(ifa.Stall), 32'd0);

    // Unit A: branch cancels a pending load stall
    ifa.IF_ID_Rs = 3'd6; ifa.ID_EX_Rt = 3'd6; ifa.ID_EX_MemRead = 1'b1;
    tick();
    clr_a();
    ifa.Branch_Taken = 1'b1;
    settle();
    chk("a_br_cancel_flush", 32'(ifa.IF_ID_Flush), 32'd1);
    chk("a_br_cancel_nostall", 32'(ifa.Stall), 32'd0);
    tick();
    clr_a();
    settle();
    chk("a_br_cancelled", 32'(ifa.Stall), 32'd0);
    chk("a_count_4", 32'(ifa.Stall_Count), 32'd4);

    // Unit A: freeze during LOAD_STALL holds the remaining two stall cycles
    ifa.IF_ID_Rs = 3'd5; ifa.ID_EX_Rt = 3'd5; ifa.ID_EX_MemRead = 1'b1;
    tick();
    clr_a();
    ifa.Mem_Busy = 1'b1;
    settle();
    chk("a_frz_freeze", 32'(ifa.Freeze), 32'd1);
    chk("a_frz_no_stall", 32'(ifa.Stall), 32'd0);
    chk("a_frz_no_bubble", 32'(ifa.ID_EX_Bubble), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    settle();
    chk("a_frz_freeze_10", 32'(ifa.Freeze), 32'd1);
    chk("a_frz_count_held", 32'(ifa.Stall_Count), 32'd5);
    tick();
    ifa.Mem_Busy = 1'b0;
    settle();
    chk("a_frz_rel_c1", 32'(ifa.Stall), 32'd1);
    tick();
    settle();
    chk("a_frz_rel_c2", 32'(ifa.Stall), 32'd1);
    tick();
    settle();
    chk("a_frz_rel_done", 32'(ifa.Stall), 32'd0);
    chk("a_count_7", 32'(ifa.Stall_Count), 32'd7);
    chk("a_no_error_yet", 32'(ifa.Mem_Error), 32'd0);

    // Unit A: 64 consecutive busy cycles set the sticky error
    ifa.Mem_Busy = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    settle();
    chk("a_err_at_63", 32'(ifa.Mem_Error), 32'd0);
    tick();
    settle();
    chk("a_err_at_64", 32'(ifa.Mem_Error), 32'd1);
    tick();
    ifa.Mem_Busy = 1'b0;
    tick();
    settle();
    chk("a_err_sticky", 32'(ifa.Mem_Error), 32'd1);
    chk("a_err_unfrozen", 32'(ifa.Freeze), 32'd0);

    // Unit A: reset mid-LOAD_STALL leaves no residue
    ifa.IF_ID_Rs = 3'd5; ifa.ID_EX_Rt = 3'd5; ifa.ID_EX_MemRead = 1'b1;
    tick();
    clr_a();
    Reset_n_a = 1'b0;
    settle();
    chk("a_rst_mid_stall", 32'(ifa.Stall), 32'd0);
    chk("a_rst_mid_err", 32'(ifa.Mem_Error), 32'd0);
    tick();
    Reset_n_a = 1'b1;
    settle();
    chk("a_rst_after_stall", 32'(ifa.Stall), 32'd0);
    chk("a_rst_after_bubble", 32'(ifa.ID_EX_Bubble), 32'd0);
    chk("a_rst_after_err", 32'(ifa.Mem_Error), 32'd0);
    chk("a_rst_after_count", 32'(ifa.Stall_Count), 32'd0);
    tick();
    settle();
    chk("a_rst_run", 32'(ifa.Stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
